tinyalu_exec: RTL

- Execution core of the TinyALU: accepts a command (op, A, B) under a start/done handshake and returns a 16-bit result.
- Sits directly upstream of the ALU functional-coverage monitor, which observes its start, done, op, A, B and result.
- Single-cycle ops: add, and, xor. Multiply runs through a fixed-latency pipeline.
- The start hold width (1-4 cycles) is what the coverage stage measures.

---
 rtl/tinyalu_pkg.sv | 14 +
 rtl/tinyalu_mul_pipe.sv | 39 +++
 rtl/tinyalu_exec.sv | 136 +++++++++++++
 3 files changed

// File: rtl/tinyalu_pkg.sv
// Shared types and constants for the TinyALU execution core.
package tinyalu_pkg;

  typedef enum logic [2:0] {
    NO_OP, ADD_OP, AND_OP, XOR_OP, MUL_OP, RSVD5, RSVD6, RSVD7
  } operation_t;

  typedef enum logic [1:0] {
    S_IDLE, S_EXEC, S_MUL, S_RELEASE
  } state_t;

  localparam int DEFAULT_MUL_LATENCY = 3;

endpackage

// File: rtl/tinyalu_mul_pipe.sv
// Registered unsigned multiplier: STAGES-deep product pipeline with a parallel valid
// shift chain. Valid bits clear on reset; product registers carry no reset.
module tinyalu_mul_pipe #(
  parameter int DATA_W = 8,
  parameter int STAGES = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_vld,
  input  logic [DATA_W-1:0]     i_a,
  input  logic [DATA_W-1:0]     i_b,
  output logic                  o_vld,
  output logic [2*DATA_W-1:0]   o_prod
);

  localparam int RES_W = 2 * DATA_W;

  logic [RES_W-1:0]  r_prod_p [STAGES];
  logic [STAGES-1:0] r_vld_p;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vld_p <= '0;
    end else begin
      r_vld_p <= {r_vld_p[STAGES-2:0], i_vld};
    end
  end

  always_ff @(posedge i_clk) begin
    r_prod_p[0] <= RES_W'(i_a) * RES_W'(i_b);
    for (int s = 1; s < STAGES; s++) begin
      r_prod_p[s] <= r_prod_p[s-1];
    end
  end

  assign o_vld  = r_vld_p[STAGES-1];
  assign o_prod = r_prod_p[STAGES-1];

endmodule

// File: rtl/tinyalu_exec.sv
// TinyALU execution core: start/done handshake, single-cycle add/and/xor, pipelined mul.
// Define ALU_PROTOCOL_CHECK_EN to add the sticky proto_err driver-protocol monitor.
import tinyalu_pkg::*;

module tinyalu_exec #(
  parameter int MUL_LATENCY = DEFAULT_MUL_LATENCY,
  parameter int DATA_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_W-1:0]     A,
  input  logic [DATA_W-1:0]     B,
  output logic                  done,
  output logic [2*DATA_W-1:0]   result,
`ifdef ALU_PROTOCOL_CHECK_EN
  output logic                  proto_err,
`endif
  output logic                  busy
);

  localparam int RES_W = 2 * DATA_W;
  localparam int CNT_W = (MUL_LATENCY > 2) ? 2 : 1;

  state_t              r_state, w_next;
  operation_t          r_op, w_op;
  logic [DATA_W-1:0]   r_a, r_b;
  logic [CNT_W-1:0]    r_cnt;
  logic                w_accept_alu, w_accept_mul, w_mul_vld;
  logic [RES_W-1:0]    w_mul_prod;
`ifdef ALU_PROTOCOL_CHECK_EN
  logic [1:0]          r_rel_cnt;
`endif

  function automatic logic [RES_W-1:0] alu_fn(input operation_t o,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    case (o)
      ADD_OP:  return RES_W'(a) + RES_W'(b);
      AND_OP:  return RES_W'(a & b);
      XOR_OP:  return RES_W'(a ^ b);
      default: return '0;
    endcase
  endfunction

  assign w_op         = operation_t'(op);
  assign w_accept_alu = (r_state == S_IDLE) && start &&
                        (w_op == ADD_OP || w_op == AND_OP || w_op == XOR_OP);
  assign w_accept_mul = (r_state == S_IDLE) && start && (w_op == MUL_OP);
  assign busy         = (r_state == S_EXEC) || (r_state == S_MUL);

  // Operands enter the pipe on the acceptance edge, the same values latched into r_a/r_b.
  tinyalu_mul_pipe #(
    .DATA_W (DATA_W),
    .STAGES (MUL_LATENCY)
  ) u_mul_pipe (
    .i_clk  (clk),
    .i_rst  (reset),
    .i_vld  (w_accept_mul),
    .i_a    (A),
    .i_b    (B),
    .o_vld  (w_mul_vld),
    .o_prod (w_mul_prod)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept_alu)      w_next = S_EXEC;
        else if (w_accept_mul) w_next = S_MUL;
      end
      S_EXEC:    w_next = S_RELEASE;
      S_MUL:     if (r_cnt == '0) w_next = S_RELEASE;
      S_RELEASE: if (!start) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done   <= 1'b0;
      result <= '0;
      r_op   <= NO_OP;
      r_a    <= '0;
      r_b    <= '0;
      r_cnt  <= '0;
`ifdef ALU_PROTOCOL_CHECK_EN
      proto_err <= 1'b0;
      r_rel_cnt <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (w_accept_alu || w_accept_mul) begin
        r_op  <= w_op;
        r_a   <= A;
        r_b   <= B;
        r_cnt <= CNT_W'(MUL_LATENCY - 1);
      end
      case (r_state)
        S_EXEC: begin
          result <= alu_fn(r_op, r_a, r_b);
          done   <= 1'b1;
        end
        S_MUL: begin
          if (r_cnt == '0) begin
            result <= w_mul_prod;
            done   <= w_mul_vld;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: ;
      endcase
`ifdef ALU_PROTOCOL_CHECK_EN
      // Command must stay stable and asserted while in flight.
      if ((r_state == S_EXEC || r_state == S_MUL) &&
          (!start || w_op != r_op || A != r_a || B != r_b))
        proto_err <= 1'b1;
      if (r_state == S_RELEASE && start) begin
        if (r_rel_cnt == 2'd2) proto_err <= 1'b1;
        else                   r_rel_cnt <= r_rel_cnt + 2'd1;
      end else begin
        r_rel_cnt <= '0;
      end
`endif
    end
  end

endmodule
